stream_rr_arbiter: RTL and testbench
====================================

# stream_rr_arbiter

Shares one downstream stream port between NUM_REQS upstream requesters using round-robin arbitration. The winner is registered into an internal 2-entry skid stage. `ready_in` therefore never depends combinationally on `ready_out`, and full throughput is sustained. The block sits in front of any shared pipeline resource (memory port, writeback bus, issue slot) that several producers must feed through a single valid/ready channel.

## Interface
- NUM_REQS, default 4: number of requesters, ≥1.
- DATAW, default 32: payload width per requester.
- SELW, derived: max(1, clog2(NUM_REQS)); width of the index fields.
- clk, input, 1: clock.
- reset, input, 1: synchronous, active-high reset.
- valid_in, input, NUM_REQS: per-requester valid.
- data_in, input, NUM_REQS*DATAW: per-requester payload; requester i occupies bits [i*DATAW +: DATAW].
- ready_in, output, NUM_REQS: per-requester accept; one-hot or zero.
- valid_out, output, 1: downstream valid.
- data_out, output, DATAW: downstream payload.
- sel_out, output, SELW: index of the requester that produced data_out.
- ready_out, input, 1: downstream accept.
- perf_stalls, output, 32: stall counter; present only with STREAM_ARB_PERF_EN.

## Operation
- Transfer rules:
  - Upstream transfer on requester i when valid_in[i] && ready_in[i].
  - Downstream transfer when valid_out && ready_out.
- Grant:
  - The arbiter selects one valid requester each cycle.
  - Search order starts at index (last_winner+1) mod NUM_REQS and wraps.
  - ready_in[i] = grant[i] && buf_ready.
  - ready_in is combinational from valid_in and registered state only.
- Pointer update:
  - last_winner updates to the granted index only on a cycle with an upstream transfer.
  - Without a transfer the pointer holds and priority does not rotate.
- Skid stage:
  - 2-entry FIFO storing {sel, data}.
  - buf_ready is registered: low only while 2 entries are held.
  - Output is the oldest entry; ordering is strictly FIFO.
- Simultaneous push and pop: occupancy unchanged, and buf_ready stays as is.
- Full with pop and no push: buf_ready rises the next cycle.
- NUM_REQS = 1: the grant is valid_in[0], and sel_out is constant 0.
- An upstream requester may drop valid_in before being granted; the arbiter imposes no stickiness.
- data_out and sel_out are don't-care while valid_out = 0.

## Timing
- Reset values:
  - valid_out = 0, occupancy = 0, buf_ready = 1.
  - last_winner = NUM_REQS-1, so requester 0 has first priority.
  - perf_stalls = 0.
  - ready_in = 0 unless a valid_in is asserted, since it is combinational.
- Latency: an upstream transfer in cycle N gives valid_out = 1 in cycle N+1 (empty stage).
- Throughput: one transfer per cycle while ready_out = 1.
- Backpressure:
  - With ready_out held low, exactly 2 transfers are accepted.
  - ready_in is 0 from the cycle after the second transfer.
- Reset mid-operation:
  - Buffered entries are discarded and valid_out is 0 the next cycle.
  - The round-robin pointer returns to NUM_REQS-1.

## Configuration
- STREAM_ARB_PERF_EN defined:
  - perf_stalls increments, wrapping at 2^32, every cycle where |valid_in && !buf_ready.
  - Reset clears it.
- Not defined: the port and the counter are absent, with no other behavioural difference.

## Structure
- Package stream_arb_pkg holds:
  - a clog2-with-floor-1 helper function for SELW;
  - the PERF_CNT_W = 32 constant;
  - a typedef for the buffer entry {sel, data}.
- One sub-module, stream_rr_grant: purely combinational rotating-priority encoder.
  - Inputs: req vector and last_winner.
  - Outputs: one-hot grant, grant index, and any_grant.
- The skid FIFO is inline in the top module.

## Test plan
- Reset, then valid_in = 4'b1111 with ready_out = 1 held:
  - grants in order 0,1,2,3,0;
  - sel_out sequence 0,1,2,3 starting one cycle after the first grant.
- Only requester 2 valid continuously, ready_out = 1: one transfer per cycle, sel_out = 2 each cycle, no bubbles.
- valid_in = 4'b0101, ready_out = 0:
  - two transfers (req 0, then req 2);
  - ready_in = 0 thereafter.
  - Raise ready_out: outputs req 0 then req 2 data in FIFO order, and ready_in reasserts one cycle after the first pop.
- Requester 1 transfers, then a 5-cycle idle gap, then requesters 1 and 3 both valid: grant goes to 3.
- Reset asserted while 2 entries are buffered: valid_out = 0 next cycle, and the first grant after reset goes to requester 0.
- With STREAM_ARB_PERF_EN: hold ready_out = 0 with req 0 valid for 10 cycles; perf_stalls = 8.

Source files
------------

// File: rtl/stream_arb_pkg.sv
// stream_rr_arbiter shared package: width helper, counter width,
// buffer entry type for the default configuration.
package stream_arb_pkg;

  localparam int PERF_CNT_W = 32;

  function automatic int clog2_floor1(input int n);
    int w;
    w = 0;
    while ((1 << w) < n) w++;
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_NUM_REQS = 4;
  localparam int DEF_DATAW    = 32;
  localparam int DEF_SELW     = clog2_floor1(DEF_NUM_REQS);

  typedef struct packed {
    logic [DEF_SELW-1:0]  sel;
    logic [DEF_DATAW-1:0] data;
  } arb_entry_t;

endpackage

// File: rtl/stream_rr_arbiter_if.sv
// stream_rr_arbiter bundle: upstream request lanes plus the
// single downstream valid/ready channel.
interface stream_rr_arbiter_if #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32
);
  import stream_arb_pkg::*;

  localparam int SELW = clog2_floor1(NUM_REQS);

  logic [NUM_REQS-1:0]       valid_in;
  logic [NUM_REQS*DATAW-1:0] data_in;
  logic [NUM_REQS-1:0]       ready_in;
  logic                      valid_out;
  logic [DATAW-1:0]          data_out;
  logic [SELW-1:0]           sel_out;
  logic                      ready_out;

  modport master (
    output valid_in, data_in, ready_out,
    input  ready_in, valid_out, data_out, sel_out
  );

  modport slave (
    input  valid_in, data_in, ready_out,
    output ready_in, valid_out, data_out, sel_out
  );

endinterface

// File: rtl/stream_rr_grant.sv
// Rotating-priority encoder: search starts one past last_i
// and wraps; combinational only.
module stream_rr_grant
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int SELW     = clog2_floor1(NUM_REQS)
) (
  input  logic [NUM_REQS-1:0] req_i,
  input  logic [SELW-1:0]     last_i,
  output logic [NUM_REQS-1:0] grant_o,
  output logic [SELW-1:0]     idx_o,
  output logic                any_o
);

  // scan from farthest to nearest so the nearest valid wins
  always_comb begin : scan
    int j;
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    j       = 0;
    for (int k = NUM_REQS; k >= 1; k--) begin
      j = (int'(last_i) + k) % NUM_REQS;
      if (req_i[j]) begin
        grant_o    = '0;
        grant_o[j] = 1'b1;
        idx_o      = SELW'(j);
        any_o      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/stream_rr_arbiter.sv
// Round-robin stream arbiter with registered 2-entry skid stage.
// Optional stall counter enabled by STREAM_ARB_PERF_EN.
module stream_rr_arbiter
  import stream_arb_pkg::*;
#(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  stream_rr_arbiter_if.slave    bus
`ifdef STREAM_ARB_PERF_EN
  ,
  output logic [PERF_CNT_W-1:0] perf_stalls
`endif
);

  localparam int SELW = clog2_floor1(NUM_REQS);

  typedef struct packed {
    logic [SELW-1:0]  sel;
    logic [DATAW-1:0] data;
  } entry_t;

  logic [NUM_REQS-1:0] grant;
  logic [SELW-1:0]     grant_idx;
  logic                any_grant;

  logic [SELW-1:0] last_q;
  logic [SELW-1:0] last_d;
  logic [1:0]      cnt_q;
  logic [1:0]      cnt_d;
  logic            buf_ready_q;
  logic            buf_ready_d;
  logic            wr_ptr_q;
  logic            rd_ptr_q;
  entry_t          mem_q [2];
  entry_t          wr_entry;

  logic push;
  logic pop;

  stream_rr_grant #(
    .NUM_REQS (NUM_REQS),
    .SELW     (SELW)
  ) u_grant (
    .req_i   (bus.valid_in),
    .last_i  (last_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (any_grant)
  );

  assign bus.ready_in  = grant & {NUM_REQS{buf_ready_q}};
  assign push          = any_grant && buf_ready_q;
  assign bus.valid_out = (cnt_q != 2'd0);
  assign pop           = bus.valid_out && bus.ready_out;
  assign bus.data_out  = mem_q[rd_ptr_q].data;
  assign bus.sel_out   = mem_q[rd_ptr_q].sel;

  assign wr_entry.sel  = grant_idx;
  assign wr_entry.data = bus.data_in[grant_idx*DATAW +: DATAW];

  // occupancy, ready and pointer next-state
  always_comb begin
    cnt_d  = cnt_q;
    last_d = last_q;
    if (push && !pop) cnt_d = cnt_q + 2'd1;
    else if (!push && pop) cnt_d = cnt_q - 2'd1;
    buf_ready_d = (cnt_d != 2'd2);
    if (push) last_d = grant_idx;
  end

  // control state; reset discards entries and rewinds priority
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q       <= 2'd0;
      buf_ready_q <= 1'b1;
      last_q      <= SELW'(NUM_REQS - 1);
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      buf_ready_q <= buf_ready_d;
      last_q      <= last_d;
      if (push) wr_ptr_q <= ~wr_ptr_q;
      if (pop)  rd_ptr_q <= ~rd_ptr_q;
    end
  end

  // payload storage, no reset needed
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_entry;
  end

`ifdef STREAM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] stalls_q;

  // count cycles where someone waits on a full stage
  always_ff @(posedge clk) begin
    if (reset) stalls_q <= '0;
    else if (|bus.valid_in && !buf_ready_q)
      stalls_q <= stalls_q + 1'b1;
  end

  assign perf_stalls = stalls_q;
`endif

endmodule

// File: tb/tb_stream_rr_arbiter.sv
// Bench for stream_rr_arbiter: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_stream_rr_arbiter;
  import stream_arb_pkg::*;

  localparam int N = 4;
  localparam int W = 32;

  logic clk;
  logic reset;

  stream_rr_arbiter_if #(.NUM_REQS(N), .DATAW(W)) bus ();

`ifdef STREAM_ARB_PERF_EN
  logic [31:0] perf_stalls;
`endif

  stream_rr_arbiter #(.NUM_REQS(N), .DATAW(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef STREAM_ARB_PERF_EN
    ,
    .perf_stalls (perf_stalls)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks;
  int failures;

  arb_entry_t  mq[$];
  int          last;
  logic [31:0] din [N];
  logic [N-1:0] obs_rdy;
  logic [1:0]   obs_sel;
  logic         obs_vout;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic [N-1:0] v, input logic ro);
    logic [N-1:0] exp_rdy;
    int gi;
    @(negedge clk);
    bus.valid_in  = v;
    bus.ready_out = ro;
    for (int i = 0; i < N; i++) begin
      din[i] = $urandom;
      bus.data_in[i*W +: W] = din[i];
    end
    #1;
    gi = -1;
    exp_rdy = '0;
    if (mq.size() < 2) begin
      for (int k = 1; k <= N; k++) begin
        int j;
        j = (last + k) % N;
        if (gi < 0 && v[j]) gi = j;
      end
    end
    if (gi >= 0) exp_rdy[gi] = 1'b1;
    obs_rdy  = bus.ready_in;
    obs_sel  = bus.sel_out;
    obs_vout = bus.valid_out;
    chk("ready_in", 32'(bus.ready_in), 32'(exp_rdy));
    chk("valid_out", 32'(bus.valid_out), 32'(mq.size() > 0));
    if (mq.size() > 0) begin
      chk("data_out", bus.data_out, mq[0].data);
      chk("sel_out", 32'(bus.sel_out), 32'(mq[0].sel));
    end
    if (mq.size() > 0 && ro) void'(mq.pop_front());
    if (gi >= 0) begin
      mq.push_back('{sel: 2'(gi), data: din[gi]});
      last = gi;
    end
  endtask

  task automatic do_reset(input logic [N-1:0] v);
    @(negedge clk);
    reset = 1'b1;
    bus.valid_in  = v;
    bus.ready_out = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    bus.valid_in = '0;
    mq.delete();
    last = N - 1;
    #1;
    chk("rst_valid_out", 32'(bus.valid_out), 32'd0);
    chk("rst_ready_in", 32'(bus.ready_in), 32'd0);
  endtask

  logic [N-1:0] exp_seq [5];
  logic [N-1:0] rv;
  logic         rro;

  initial begin
    checks   = 0;
    failures = 0;
    reset    = 1'b1;
    last     = N - 1;
    bus.valid_in  = '0;
    bus.data_in   = '0;
    bus.ready_out = 1'b0;
    repeat (2) @(posedge clk);
    do_reset('0);

    exp_seq[0] = 4'b0001;
    exp_seq[1] = 4'b0010;
    exp_seq[2] = 4'b0100;
    exp_seq[3] = 4'b1000;
    exp_seq[4] = 4'b0001;
    for (int i = 0; i < 5; i++) begin
      step(4'b1111, 1'b1);
      chk("rr_order", 32'(obs_rdy), 32'(exp_seq[i]));
      if (i > 0) chk("rr_sel", 32'(obs_sel), i - 1);
    end

    for (int i = 0; i < 6; i++) begin
      step(4'b0100, 1'b1);
      if (i > 0) begin
        chk("solo_vout", 32'(obs_vout), 32'd1);
        chk("solo_sel", 32'(obs_sel), 32'd2);
      end
    end

    do_reset('0);
    step(4'b0101, 1'b0);
    chk("bp_first", 32'(obs_rdy), 32'(4'b0001));
    step(4'b0101, 1'b0);
    chk("bp_second", 32'(obs_rdy), 32'(4'b0100));
    step(4'b0101, 1'b0);
    chk("bp_full", 32'(obs_rdy), 32'd0);
    step(4'b0101, 1'b1);
    chk("bp_pop_rdy", 32'(obs_rdy), 32'd0);
    chk("bp_pop_sel", 32'(obs_sel), 32'd0);
    step(4'b0101, 1'b1);
    chk("bp_reassert", 32'(obs_rdy), 32'(4'b0001));
    chk("bp_pop2_sel", 32'(obs_sel), 32'd2);

    do_reset('0);
    step(4'b0010, 1'b1);
    repeat (5) step(4'b0000, 1'b1);
    step(4'b1010, 1'b1);
    chk("idle_gap", 32'(obs_rdy), 32'(4'b1000));

    step(4'b1111, 1'b0);
    step(4'b1111, 1'b0);
    do_reset(4'b1111);
    step(4'b1111, 1'b1);
    chk("post_rst_grant", 32'(obs_rdy), 32'(4'b0001));

`ifdef STREAM_ARB_PERF_EN
    do_reset('0);
    chk("perf_rst", perf_stalls, 32'd0);
    repeat (10) step(4'b0001, 1'b0);
    @(negedge clk);
    chk("perf_stalls", perf_stalls, 32'd8);
`endif

    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 59) == 0) begin
        do_reset(4'($urandom));
      end else begin
        rv  = 4'($urandom);
        rro = ($urandom_range(0, 3) != 0);
        step(rv, rro);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
